dl_seq_adder: RTL and testbench
===============================

# dl_seq_adder

Multi-cycle wide adder controller. It sequences one narrow `dl_adder` instance across the words of a wide operand pair, propagating carry between words, and exposes valid/ready handshakes on both sides. It sits in the design library as the area-cheap alternative to a full-width `dl_adder` wherever a wide sum can tolerate multi-cycle latency, for example in address or counter arithmetic.

## Interface
- `NUM_BITS`, default 8: width of one word, which is the width of the shared chunk adder.
- `NUM_WORDS`, default 4, minimum 1: number of words per operand. Total width W = NUM_BITS*NUM_WORDS.
- `clk` input 1: the only clock.
- `rst_n` input 1: synchronous active-low reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept operands.
- `in_a` input W: operand A.
- `in_b` input W: operand B.
- `in_cin` input 1: carry-in to the LSB word.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output W: result, (in_a + in_b + in_cin) mod 2^W.
- `out_cout` output 1: carry out of bit W-1.
- `out_ovf` output 1: signed overflow. Present only with DL_SEQ_ADDER_OVF_EN.

## Operation
- There is exactly one `dl_adder #(.NUM_BITS(NUM_BITS+1))`.
  - Its a input is {word_a, 1'b1} and its b input is {word_b, carry_q}.
  - Chunk sum = adder sum[NUM_BITS:1]. Chunk carry = adder cout.
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid`&&`in_ready`, capture `in_a`/`in_b` into shift registers, set carry_q=`in_cin`, set idx=0, and go to BUSY.
  - BUSY: each cycle, add the LSB words of the A/B shift registers. Shift the chunk sum into the MSB end of the result register, shift A/B right by NUM_BITS, update carry_q, and increment idx. When idx==NUM_WORDS-1, go to DONE.
  - DONE: `out_valid`=1, `out_cout`=carry_q. On `out_valid`&&`out_ready`, go to IDLE.
- idx width is max(1, $clog2(NUM_WORDS)). It never wraps past NUM_WORDS-1.
- `in_valid` is ignored outside IDLE. Operands are sampled only on the accept cycle, so changes to `in_a`/`in_b`/`in_cin` after accept have no effect.
- `out_sum`, `out_cout` and `out_ovf` are held stable for the entire time `out_valid` is high.
- `in_ready` is never high while `out_valid` is high. There is no accept in the same cycle as result handoff.
- NUM_WORDS=1: the block spends one BUSY cycle, then goes to DONE.

## Timing
- Reset (rst_n low at a clk edge):
  - state goes to IDLE.
  - `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0.
  - `in_ready`=0 while rst_n is low, and 1 from the first cycle after release.
- Reset mid-operation (BUSY or DONE) aborts the operation. The pending result is discarded and never presented.
- Accept at edge 0 gives BUSY on cycles 1..NUM_WORDS, then `out_valid` high from cycle NUM_WORDS+1.
- Latency is NUM_WORDS+1 cycles from accept to `out_valid`.
- Handoff at edge k gives IDLE with `in_ready`=1 at cycle k+1.
- Minimum issue interval is NUM_WORDS+2 cycles.
- Backpressure (`out_ready` low) holds DONE indefinitely. This is not an error.

## Configuration
- With DL_SEQ_ADDER_OVF_EN defined, the `out_ovf` port exists.
  - The MSBs of A and B are registered at accept.
  - In DONE, `out_ovf` = (a_msb==b_msb) && (out_sum[W-1]!=a_msb), which is two's-complement overflow including cin.
  - `out_ovf` is held like `out_sum`.
- Without the macro, the port and its registers are absent, and all other behaviour is identical.

## Test plan
All scenarios use NUM_BITS=8, NUM_WORDS=4.
- Carry ripple across all words: accept A=0xFFFFFFFF, B=0x00000001, cin=0 -> `out_sum`=0x00000000, `out_cout`=1, `out_valid` rises exactly 5 cycles after accept.
- Carry-in: accept A=0x12345678, B=0x11111111, cin=1 -> `out_sum`=0x2345678A, `out_cout`=0.
- Backpressure: same result as above with `out_ready` held low for 3 cycles after `out_valid` -> `out_valid`/`out_sum` stable, `in_ready`=0 throughout; `in_ready`=1 the cycle after `out_ready` goes high.
- Ignored input: drive `in_valid`=1 with A=0xDEADBEEF during BUSY -> no second accept, and the first result is unchanged.
- Reset mid-op: assert rst_n=0 for one edge in the third BUSY cycle -> `out_valid`=0, `out_sum`=0, `in_ready`=1 after release; then accept 0x00000002+0x00000003 -> `out_sum`=0x00000005.
- With DL_SEQ_ADDER_OVF_EN: accept 0x7FFFFFFF+0x00000001 -> `out_ovf`=1, `out_cout`=0; accept 0xFFFFFFFF+0x00000001 -> `out_ovf`=0, `out_cout`=1.

Source files
------------

// File: rtl/dl_seq_adder.sv
// Multi-cycle wide adder: one narrow chunk adder reused across NUM_WORDS words with carry held between steps.
// Optional signed-overflow output enabled by defining DL_SEQ_ADDER_OVF_EN.

module dl_adder #(
    parameter int unsigned NUM_BITS = 8
) (
    input  logic [NUM_BITS-1:0] i_a,
    input  logic [NUM_BITS-1:0] i_b,
    output logic [NUM_BITS-1:0] o_sum_c,
    output logic                o_cout_c
);
    localparam int unsigned SW = NUM_BITS + 1;

    assign {o_cout_c, o_sum_c} = SW'(i_a) + SW'(i_b);
endmodule

module dl_seq_adder #(
    parameter int unsigned NUM_BITS  = 8,
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_BITS*NUM_WORDS-1:0] in_a,
    input  logic [NUM_BITS*NUM_WORDS-1:0] in_b,
    input  logic                          in_cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_BITS*NUM_WORDS-1:0] out_sum,
`ifdef DL_SEQ_ADDER_OVF_EN
    output logic                          out_ovf,
`endif
    output logic                          out_cout
);
    localparam int unsigned W     = NUM_BITS * NUM_WORDS;
    localparam int unsigned AW    = NUM_BITS + 1;
    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_accept;
    logic               w_step;
    logic               w_last;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;

    logic [AW-1:0]      w_add_a;
    logic [AW-1:0]      w_add_b;
    logic [AW-1:0]      w_add_sum;
    logic               w_add_cout;
    logic [NUM_BITS-1:0] w_chunk;
    logic               w_sum_lsb_unused;
    logic [W-1:0]       w_sum_nxt;

    // LSB pair {1, carry} turns the carry into a carry-in for the word bits.
    assign w_add_a = {r_a[NUM_BITS-1:0], 1'b1};
    assign w_add_b = {r_b[NUM_BITS-1:0], r_carry};

    dl_adder #(.NUM_BITS(AW)) u_chunk_adder (
        .i_a      (w_add_a),
        .i_b      (w_add_b),
        .o_sum_c  (w_add_sum),
        .o_cout_c (w_add_cout)
    );

    assign w_chunk          = w_add_sum[AW-1:1];
    assign w_sum_lsb_unused = w_add_sum[0];
    assign w_sum_nxt        = (r_sum >> NUM_BITS) | (W'(w_chunk) << (W - NUM_BITS));
    assign w_last           = (r_idx == IDX_W'(NUM_WORDS - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_step          = 1'b0;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Handshake outputs are registered from the next state.
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

`ifdef DL_SEQ_ADDER_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
    logic w_ovf_nxt;

    assign w_ovf_nxt = (r_a_msb == r_b_msb) && (w_chunk[NUM_BITS-1] != r_a_msb);
    assign out_ovf   = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= in_a[W-1];
            r_b_msb <= in_b[W-1];
        end else if (w_step && w_last) begin
            r_ovf   <= w_ovf_nxt;
        end
    end
`endif

    // Word-serial datapath; result words enter at the MSB end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> NUM_BITS;
            r_b     <= r_b >> NUM_BITS;
            r_sum   <= w_sum_nxt;
            r_carry <= w_add_cout;
            if (w_last) begin
                r_cout <= w_add_cout;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule

// File: tb/tb_dl_seq_adder.sv
// Directed self-checking bench for dl_seq_adder (NUM_BITS=8, NUM_WORDS=4).
module tb_dl_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
`ifdef DL_SEQ_ADDER_OVF_EN
    logic        out_ovf;
`endif

    int errors = 0;
    int checks = 0;
    int lat;
    logic [31:0] held_sum;

    always #5 clk = ~clk;

    dl_seq_adder #(.NUM_BITS(8), .NUM_WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef DL_SEQ_ADDER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_cout  (out_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one operand pair for one cycle; returns at the negedge after the accept edge.
    task automatic do_accept(input logic [31:0] a, input logic [31:0] b, input logic cin);
        chk("ready_before_accept", 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge (=1) until out_valid is seen, bounded.
    task automatic wait_valid(output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("release_in_ready", 64'(in_ready), 64'd1);

        // Carry ripple across every word.
        do_accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        wait_valid(lat);
        chk("ripple_latency", 64'(lat), 64'd5);
        chk("ripple_sum", 64'(out_sum), 64'h0000_0000);
        chk("ripple_cout", 64'(out_cout), 64'd1);
        handoff();

        // Carry-in, backpressure, and ignored in_valid / operand changes during BUSY.
        do_accept(32'h1234_5678, 32'h1111_1111, 1'b1);
        in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'hDEAD_BEEF; in_cin = 1'b0;
        wait_valid(lat);
        in_valid = 1'b0;
        chk("cin_latency", 64'(lat), 64'd5);
        chk("cin_sum", 64'(out_sum), 64'h2345_678A);
        chk("cin_cout", 64'(out_cout), 64'd0);
        chk("cin_in_ready", 64'(in_ready), 64'd0);
        held_sum = out_sum;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_sum", 64'(out_sum), 64'h2345_678A);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        chk("bp_sum_stable", 64'(out_sum), 64'(held_sum));
        handoff();
        tick();
        chk("no_second_accept", 64'(out_valid), 64'd0);

        // Both words at sign boundary with carry-in.
        do_accept(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_valid(lat);
        chk("msb_sum", 64'(out_sum), 64'h0000_0001);
        chk("msb_cout", 64'(out_cout), 64'd1);
        handoff();

        // Reset during the third BUSY cycle discards the operation.
        do_accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sum", 64'(out_sum), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_release_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_no_result", 64'(out_valid), 64'd0);
        do_accept(32'h0000_0002, 32'h0000_0003, 1'b0);
        wait_valid(lat);
        chk("post_rst_latency", 64'(lat), 64'd5);
        chk("post_rst_sum", 64'(out_sum), 64'h0000_0005);
        chk("post_rst_cout", 64'(out_cout), 64'd0);
        handoff();

`ifdef DL_SEQ_ADDER_OVF_EN
        do_accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid(lat);
        chk("ovf_pos_sum", 64'(out_sum), 64'h8000_0000);
        chk("ovf_pos_ovf", 64'(out_ovf), 64'd1);
        chk("ovf_pos_cout", 64'(out_cout), 64'd0);
        handoff();
        do_accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid(lat);
        chk("ovf_neg_ovf", 64'(out_ovf), 64'd0);
        chk("ovf_neg_cout", 64'(out_cout), 64'd1);
        handoff();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
